// File: rtl/alu_ctrl_pkg.sv
// rtl/alu_ctrl_pkg.sv - ALUOp/Funct constants, ALU control codes and sequencer states
package alu_ctrl_pkg;

    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_SUB   = 3'b001;
    localparam logic [2:0] OP_RTYPE = 3'b010;
    localparam logic [2:0] OP_AND   = 3'b100;
    localparam logic [2:0] OP_OR    = 3'b110;
    localparam logic [2:0] OP_SLT   = 3'b111;

    localparam logic [5:0] FN_NOP   = 6'b000000;
    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MFLO  = 6'b010010;
    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;
    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_NOR   = 6'b100111;
    localparam logic [5:0] FN_SLT   = 6'b101010;

    localparam logic [3:0] CTL_AND     = 4'b0000;
    localparam logic [3:0] CTL_OR      = 4'b0001;
    localparam logic [3:0] CTL_ADD     = 4'b0010;
    localparam logic [3:0] CTL_SUB     = 4'b0110;
    localparam logic [3:0] CTL_SLT     = 4'b0111;
    localparam logic [3:0] CTL_MFHI    = 4'b1000;
    localparam logic [3:0] CTL_MFLO    = 4'b1001;
    localparam logic [3:0] CTL_MULDIV  = 4'b1010;
    localparam logic [3:0] CTL_NOR     = 4'b1100;
    localparam logic [3:0] CTL_ILLEGAL = 4'b1111;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_MUL  = 3'd1;
    localparam logic [2:0] S_DIV  = 3'd2;
    localparam logic [2:0] S_FIX  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

endpackage

// File: rtl/muldiv_iter.sv
// rtl/muldiv_iter.sv - shift-add multiply / restoring divide datapath with sign fix-up and HI/LO
module muldiv_iter
    import alu_ctrl_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             div_i,
    input  logic             sgn_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             step_i,
    input  logic             fix_i,
    output logic             last_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    logic [WIDTH-1:0]   acc_q, sh_q, mc_q, cnt_q, hi_q, lo_q;
    logic               div_q, neg_q, negr_q;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     mul_sum, div_sh;
    logic [WIDTH+1:0]   div_diff;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;
    logic               unused_bits;

    assign mag_a = (sgn_i && a_i[WIDTH-1]) ? -a_i : a_i;
    assign mag_b = (sgn_i && b_i[WIDTH-1]) ? -b_i : b_i;

    assign mul_sum  = sh_q[0] ? ({1'b0, acc_q} + {1'b0, mc_q}) : {1'b0, acc_q};
    assign div_sh   = {acc_q, sh_q[WIDTH-1]};
    assign div_diff = {1'b0, div_sh} - {2'b00, mc_q};

    assign prod     = {acc_q, sh_q};
    assign prod_fix = neg_q ? -prod : prod;
    assign quo_fix  = neg_q ? -sh_q : sh_q;
    assign rem_fix  = negr_q ? -acc_q : acc_q;

    assign unused_bits = div_diff[WIDTH];

    // cnt_q walks a single one from bit 0 to bit WIDTH-1, one position per iteration
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q  <= '0;
            sh_q   <= '0;
            mc_q   <= '0;
            cnt_q  <= '0;
            div_q  <= 1'b0;
            neg_q  <= 1'b0;
            negr_q <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
        end else if (start_i) begin
            acc_q  <= '0;
            sh_q   <= div_i ? mag_a : mag_b;
            mc_q   <= div_i ? mag_b : mag_a;
            cnt_q  <= WIDTH'(1);
            div_q  <= div_i;
            neg_q  <= sgn_i & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
            negr_q <= sgn_i & a_i[WIDTH-1];
        end else if (step_i) begin
            cnt_q <= cnt_q << 1;
            if (!div_q) begin
                acc_q <= mul_sum[WIDTH:1];
                sh_q  <= {mul_sum[0], sh_q[WIDTH-1:1]};
            end else if (!div_diff[WIDTH+1]) begin
                acc_q <= div_diff[WIDTH-1:0];
                sh_q  <= {sh_q[WIDTH-2:0], 1'b1};
            end else begin
                acc_q <= div_sh[WIDTH-1:0];
                sh_q  <= {sh_q[WIDTH-2:0], 1'b0};
            end
        end else if (fix_i) begin
            hi_q <= div_q ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
            lo_q <= div_q ? quo_fix : prod_fix[WIDTH-1:0];
        end
    end

    assign last_o = cnt_q[WIDTH-1];
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;

endmodule

// File: rtl/alu_control_seq.sv
// rtl/alu_control_seq.sv - registered ALU control decoder with mul/div sequencer (ALUCTL_MULDIV_EN)
module alu_control_seq
    import alu_ctrl_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int OPW   = 3,
    parameter int CTLW  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Start,
    input  logic [OPW-1:0]   ALUOp,
    input  logic [5:0]       Funct,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [CTLW-1:0]  Salida,
    output logic             Error,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo
);

    logic [3:0]      dec_ctl;
    logic            dec_err, dec_mul, dec_div, dec_sgn;
    logic            accept, busy, div_zero;
    logic [CTLW-1:0] salida_q;
    logic            error_q;

    always_comb begin
        dec_ctl = CTL_ILLEGAL;
        dec_err = 1'b1;
        dec_mul = 1'b0;
        dec_div = 1'b0;
        dec_sgn = 1'b0;
        case (ALUOp)
            OPW'(OP_ADD): begin dec_ctl = CTL_ADD; dec_err = 1'b0; end
            OPW'(OP_SUB): begin dec_ctl = CTL_SUB; dec_err = 1'b0; end
            OPW'(OP_AND): begin dec_ctl = CTL_AND; dec_err = 1'b0; end
            OPW'(OP_OR):  begin dec_ctl = CTL_OR;  dec_err = 1'b0; end
            OPW'(OP_SLT): begin dec_ctl = CTL_SLT; dec_err = 1'b0; end
            OPW'(OP_RTYPE): begin
                dec_err = 1'b0;
                case (Funct)
                    FN_ADD, FN_NOP: dec_ctl = CTL_ADD;
                    FN_SUB:         dec_ctl = CTL_SUB;
                    FN_AND:         dec_ctl = CTL_AND;
                    FN_OR:          dec_ctl = CTL_OR;
                    FN_SLT:         dec_ctl = CTL_SLT;
                    FN_NOR:         dec_ctl = CTL_NOR;
`ifdef ALUCTL_MULDIV_EN
                    FN_MFHI:        dec_ctl = CTL_MFHI;
                    FN_MFLO:        dec_ctl = CTL_MFLO;
                    FN_MULT, FN_MULTU: begin
                        dec_ctl = CTL_MULDIV;
                        dec_mul = 1'b1;
                        dec_sgn = ~Funct[0];
                    end
                    FN_DIV, FN_DIVU: begin
                        dec_ctl = CTL_MULDIV;
                        dec_div = 1'b1;
                        dec_sgn = ~Funct[0];
                    end
`endif
                    default:        dec_err = 1'b1;
                endcase
            end
            default: ;
        endcase
    end

    assign accept = Start && !busy;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            salida_q <= CTLW'(CTL_ADD);
            error_q  <= 1'b0;
        end else if (accept) begin
            salida_q <= CTLW'(dec_ctl);
            error_q  <= dec_err | div_zero;
        end
    end

    assign Salida = salida_q;
    assign Error  = error_q;

`ifdef ALUCTL_MULDIV_EN
    logic [2:0] state_q, state_d;
    logic       launch, last;

    assign div_zero = dec_div && (B == '0);
    assign launch   = accept && (dec_mul || (dec_div && !div_zero));

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                // DONE falls back to IDLE unless a new op is accepted at the same edge
                state_d = S_IDLE;
                if (accept && dec_mul)
                    state_d = S_MUL;
                else if (accept && dec_div)
                    state_d = div_zero ? S_DONE : S_DIV;
            end
            S_MUL, S_DIV: if (last) state_d = S_FIX;
            S_FIX:        state_d = S_DONE;
            default:      state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    assign busy = (state_q == S_MUL) || (state_q == S_DIV) || (state_q == S_FIX);
    assign Busy = busy;
    assign Done = (state_q == S_DONE);

    muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
        .clk     (clk),
        .rst     (reset),
        .start_i (launch),
        .div_i   (dec_div),
        .sgn_i   (dec_sgn),
        .a_i     (A),
        .b_i     (B),
        .step_i  ((state_q == S_MUL) || (state_q == S_DIV)),
        .fix_i   (state_q == S_FIX),
        .last_o  (last),
        .hi_o    (Hi),
        .lo_o    (Lo)
    );
`else
    logic unused_sig;

    assign div_zero   = 1'b0;
    assign busy       = 1'b0;
    assign Busy       = 1'b0;
    assign Done       = 1'b0;
    assign Hi         = '0;
    assign Lo         = '0;
    assign unused_sig = ^{A, B, dec_mul, dec_div, dec_sgn};
`endif

endmodule

// File: tb/tb_alu_control_seq.sv
// tb/tb_alu_control_seq.sv - randomized and directed bench for alu_control_seq against a reference model
module tb_alu_control_seq;

    localparam int W = 32;
`ifdef ALUCTL_MULDIV_EN
    localparam bit EN = 1'b1;
`else
    localparam bit EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         Start;
    logic [2:0]   ALUOp;
    logic [5:0]   Funct;
    logic [W-1:0] A, B;
    logic [3:0]   Salida;
    logic         Error, Busy, Done;
    logic [W-1:0] Hi, Lo;

    int           checks = 0;
    int           failures = 0;
    logic [W-1:0] mhi = '0;
    logic [W-1:0] mlo = '0;

    logic [5:0] fn_list [14] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010,
                                 6'b100111, 6'b000000, 6'b010000, 6'b010010, 6'b011000,
                                 6'b011001, 6'b011010, 6'b011011, 6'b110011};

    alu_control_seq dut (
        .clk    (clk),
        .reset  (reset),
        .Start  (Start),
        .ALUOp  (ALUOp),
        .Funct  (Funct),
        .A      (A),
        .B      (B),
        .Salida (Salida),
        .Error  (Error),
        .Busy   (Busy),
        .Done   (Done),
        .Hi     (Hi),
        .Lo     (Lo)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // kind: 0 plain decode, 1 multiply, 2 divide
    function automatic void ref_dec(input logic [2:0] op, input logic [5:0] f,
                                    output logic [3:0] ctl, output logic err, output int kind);
        ctl = 4'hF; err = 1'b1; kind = 0;
        case (op)
            3'd0: begin ctl = 4'b0010; err = 1'b0; end
            3'd1: begin ctl = 4'b0110; err = 1'b0; end
            3'd4: begin ctl = 4'b0000; err = 1'b0; end
            3'd6: begin ctl = 4'b0001; err = 1'b0; end
            3'd7: begin ctl = 4'b0111; err = 1'b0; end
            3'd2: begin
                err = 1'b0;
                case (f)
                    6'b100000, 6'b000000: ctl = 4'b0010;
                    6'b100010: ctl = 4'b0110;
                    6'b100100: ctl = 4'b0000;
                    6'b100101: ctl = 4'b0001;
                    6'b101010: ctl = 4'b0111;
                    6'b100111: ctl = 4'b1100;
                    6'b010000: if (EN) ctl = 4'b1000; else err = 1'b1;
                    6'b010010: if (EN) ctl = 4'b1001; else err = 1'b1;
                    6'b011000, 6'b011001: if (EN) begin ctl = 4'b1010; kind = 1; end else err = 1'b1;
                    6'b011010, 6'b011011: if (EN) begin ctl = 4'b1010; kind = 2; end else err = 1'b1;
                    default: err = 1'b1;
                endcase
            end
            default: ;
        endcase
    endfunction

    function automatic void ref_muldiv(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                                       output logic [W-1:0] h, output logic [W-1:0] l);
        longint sa, sb, sp;
        logic [63:0] ua, ub, up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (f)
            6'b011000: begin sp = sa * sb; {h, l} = sp; end
            6'b011001: begin up = ua * ub; {h, l} = up; end
            6'b011010: begin l = W'(sa / sb); h = W'(sa % sb); end
            default:   begin l = W'(ua / ub); h = W'(ua % ub); end
        endcase
    endfunction

    function automatic logic [W-1:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return W'($urandom_range(1, 40));
            default: return W'($urandom);
        endcase
    endfunction

    task automatic do_op(input logic [2:0] op, input logic [5:0] f, input logic [W-1:0] a,
                         input logic [W-1:0] b, input bit poke);
        logic [3:0]   ectl;
        logic         eerr, bz;
        int           kind, cyc, busy_cnt;
        logic [W-1:0] nh, nl;
        ref_dec(op, f, ectl, eerr, kind);
        bz = (kind == 2) && (b == '0);
        Start = 1'b1; ALUOp = op; Funct = f; A = a; B = b;
        tick;
        Start = 1'b0; A = $urandom; B = $urandom;
        check("salida", 64'(Salida), 64'(ectl));
        check("error", 64'(Error), 64'(eerr | bz));
        if (kind != 0 && !bz) begin
            ref_muldiv(f, a, b, nh, nl);
            cyc = 1;
            busy_cnt = 0;
            while (Done !== 1'b1 && cyc < 50) begin
                if (Busy === 1'b1) busy_cnt++;
                if (poke) begin
                    Start = 1'b1; ALUOp = 3'b010; Funct = 6'b100000;
                end
                tick;
                cyc++;
            end
            Start = 1'b0;
            check("done_cycle", 64'(cyc), 64'(W + 2));
            check("busy_cycles", 64'(busy_cnt), 64'(W + 1));
            check("busy_at_done", 64'(Busy), 64'(0));
            check("salida_held", 64'(Salida), 64'(ectl));
            mhi = nh;
            mlo = nl;
        end else begin
            check("busy_idle", 64'(Busy), 64'(0));
            check("done_flag", 64'(Done), 64'(bz));
        end
        check("hi", 64'(Hi), 64'(mhi));
        check("lo", 64'(Lo), 64'(mlo));
    endtask

    initial begin
        logic [3:0] ectl;
        logic       eerr;
        int         kind;

        reset = 1'b1; Start = 1'b0; ALUOp = '0; Funct = '0; A = '0; B = '0;
        repeat (2) tick;
        check("rst_salida", 64'(Salida), 64'h2);
        check("rst_error", 64'(Error), 64'h0);
        check("rst_busy", 64'(Busy), 64'h0);
        check("rst_done", 64'(Done), 64'h0);
        check("rst_hi", 64'(Hi), 64'h0);
        check("rst_lo", 64'(Lo), 64'h0);
        reset = 1'b0;
        tick;

        do_op(3'b010, 6'b100000, W'($urandom), W'($urandom), 1'b0);
        do_op(3'b010, 6'b110011, W'($urandom), W'($urandom), 1'b0);
        do_op(3'b010, 6'b100000, W'($urandom), W'($urandom), 1'b0);
        do_op(3'b010, 6'b011000, 32'hFFFF_FFFD, 32'h0000_0007, 1'b1);
        do_op(3'b010, 6'b011001, 32'hFFFF_FFFD, 32'h0000_0007, 1'b0);
        do_op(3'b010, 6'b010000, '0, '0, 1'b0);
        do_op(3'b010, 6'b011011, 32'd100, 32'd7, 1'b0);
        do_op(3'b010, 6'b011010, 32'hFFFF_FFF9, 32'd2, 1'b0);
        do_op(3'b010, 6'b011010, 32'h1234_5678, 32'd0, 1'b0);
        do_op(3'b010, 6'b010010, '0, '0, 1'b0);
        do_op(3'b010, 6'b011010, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        for (int op = 0; op < 8; op++)
            do_op(3'(op), 6'($urandom), W'($urandom), W'($urandom), 1'b0);

        for (int i = 0; i < 40; i++) begin
            logic [2:0] op;
            logic [5:0] f;
            int         sel;
            op  = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, 7)) : 3'b010;
            sel = $urandom_range(0, 15);
            f   = (sel < 14) ? fn_list[sel] : 6'($urandom);
            do_op(op, f, pick_operand(), pick_operand(), ($urandom_range(0, 3) == 0));
        end

        // asynchronous reset in the middle of a multiply
        ref_dec(3'b010, 6'b011000, ectl, eerr, kind);
        Start = 1'b1; ALUOp = 3'b010; Funct = 6'b011000; A = W'($urandom); B = W'($urandom);
        tick;
        Start = 1'b0;
        repeat (9) tick;
        check("busy_pre_rst", 64'(Busy), 64'(kind != 0));
        #2 reset = 1'b1;
        #1;
        check("arst_busy", 64'(Busy), 64'h0);
        check("arst_done", 64'(Done), 64'h0);
        check("arst_hi", 64'(Hi), 64'h0);
        check("arst_lo", 64'(Lo), 64'h0);
        check("arst_salida", 64'(Salida), 64'h2);
        check("arst_error", 64'(Error), 64'h0);
        tick;
        reset = 1'b0;
        mhi = '0;
        mlo = '0;
        do_op(3'b010, 6'b100010, W'($urandom), W'($urandom), 1'b0);
        do_op(3'b010, 6'b011000, W'($urandom), W'($urandom), 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
